// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forward history buffer.
// Holds the record struct that one history stage stores for one table,
// and the one-hot test used to validate slot selects.
package fwd_pkg;

    localparam int FWD_KEY_WIDTH   = 4;
    localparam int FWD_DATA_WIDTH  = 8;
    localparam int FWD_BUCKET_SIZE = 2;
    localparam int FWD_ADR_WIDTH   = 3;

    // One forwarding record; updated_mem == 0 marks an empty record.
    typedef struct packed {
        logic [FWD_ADR_WIDTH-1:0]   adr;
        logic [FWD_DATA_WIDTH-1:0]  data;
        logic [FWD_KEY_WIDTH-1:0]   key;
        logic [FWD_BUCKET_SIZE-1:0] updated_mem;
        logic [FWD_BUCKET_SIZE-1:0] valid;
    } fwd_record_t;

    // True when exactly one bit of the slot select is set.
    function automatic logic is_onehot(input logic [FWD_BUCKET_SIZE-1:0] v);
        logic [FWD_BUCKET_SIZE-1:0] v_minus_one;
        v_minus_one = v - {{(FWD_BUCKET_SIZE-1){1'b0}}, 1'b1};
        return (v != {FWD_BUCKET_SIZE{1'b0}}) &&
               ((v & v_minus_one) == {FWD_BUCKET_SIZE{1'b0}});
    endfunction

endpackage

// File: rtl/forward_history_stage.sv
// One history stage for one table: a single record register.
// On an enabled edge it loads the incoming record (optionally emptied by a
// flush, optionally with a superseded slot masked out). With the enable low
// it holds, except that a flush still empties it.
module forward_history_stage
    import fwd_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_clk_en,
    input  logic                       i_flush,
    input  logic                       i_clear_incoming,
    input  fwd_record_t                i_rec,
    input  logic [FWD_BUCKET_SIZE-1:0] i_drop_mask,
    output fwd_record_t                o_rec
);

    fwd_record_t r_rec;
    fwd_record_t w_next;

    // Shape the record about to be loaded: empty it on flush, else mask dropped slots.
    always_comb begin
        w_next = i_rec;
        if (i_clear_incoming) begin
            w_next.updated_mem = {FWD_BUCKET_SIZE{1'b0}};
            w_next.valid       = {FWD_BUCKET_SIZE{1'b0}};
        end else begin
            w_next.updated_mem = i_rec.updated_mem & ~i_drop_mask;
            w_next.valid       = i_rec.valid & ~i_drop_mask;
        end
    end

    // Record register: reset, shift on enable, flush-only clear while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rec <= '0;
        end else if (i_clk_en) begin
            r_rec <= w_next;
        end else if (i_flush) begin
            r_rec.updated_mem <= {FWD_BUCKET_SIZE{1'b0}};
            r_rec.valid       <= {FWD_BUCKET_SIZE{1'b0}};
        end else begin
            r_rec <= r_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/forward_history_buffer.sv
// Forward history buffer: records every committed bucket-slot write per
// table and keeps it for FORWARDED_CLOCK_CYCLES enabled edges. Stage 0 is
// the youngest write. Flattened outputs place stage k / table t at index
// (k*NUMBER_OF_TABLES + t) of each field.
// Optional feature macro: FWD_HISTORY_COLLAPSE_EN -- when defined, a new
// write clears the same slot in older records of the same table and address.
module forward_history_buffer
    import fwd_pkg::*;
#(
    parameter int KEY_WIDTH              = FWD_KEY_WIDTH,
    parameter int DATA_WIDTH             = FWD_DATA_WIDTH,
    parameter int NUMBER_OF_TABLES       = 3,
    parameter int BUCKET_SIZE            = FWD_BUCKET_SIZE,
    parameter int FORWARDED_CLOCK_CYCLES = 2,
    parameter int MAX_HASH_ADR_WIDTH     = FWD_ADR_WIDTH
) (
    input  logic                                                          clk,
    input  logic                                                          reset,
    input  logic                                                          clk_en,
    input  logic                                                          flush_i,
    input  logic [NUMBER_OF_TABLES-1:0]                                   wr_en_i,
    input  logic [MAX_HASH_ADR_WIDTH*NUMBER_OF_TABLES-1:0]                wr_hash_adr_i,
    input  logic [BUCKET_SIZE*NUMBER_OF_TABLES-1:0]                       wr_slot_i,
    input  logic [DATA_WIDTH*NUMBER_OF_TABLES-1:0]                        wr_data_i,
    input  logic [KEY_WIDTH*NUMBER_OF_TABLES-1:0]                         wr_key_i,
    input  logic [NUMBER_OF_TABLES-1:0]                                   wr_valid_i,
    output logic [MAX_HASH_ADR_WIDTH*NUMBER_OF_TABLES*FORWARDED_CLOCK_CYCLES-1:0] fwd_hash_adr_o,
    output logic [DATA_WIDTH*NUMBER_OF_TABLES*FORWARDED_CLOCK_CYCLES-1:0]         fwd_data_o,
    output logic [KEY_WIDTH*NUMBER_OF_TABLES*FORWARDED_CLOCK_CYCLES-1:0]          fwd_key_o,
    output logic [BUCKET_SIZE*NUMBER_OF_TABLES*FORWARDED_CLOCK_CYCLES-1:0]        fwd_updated_mem_o,
    output logic [BUCKET_SIZE*NUMBER_OF_TABLES*FORWARDED_CLOCK_CYCLES-1:0]        fwd_valid_o,
    output logic                                                          slot_err_o
);

    fwd_record_t                w_new      [NUMBER_OF_TABLES];
    fwd_record_t                w_rec      [FORWARDED_CLOCK_CYCLES][NUMBER_OF_TABLES];
    logic [BUCKET_SIZE-1:0]     w_live_slot[NUMBER_OF_TABLES];
    logic [NUMBER_OF_TABLES-1:0] w_bad;
    logic                       r_slot_err;

    // Build the stage-0 candidate record of each table; malformed slots are dropped.
    for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_new
        logic [BUCKET_SIZE-1:0] w_slot;
        assign w_slot         = wr_slot_i[t*BUCKET_SIZE +: BUCKET_SIZE];
        assign w_bad[t]       = wr_en_i[t] && !is_onehot(w_slot);
        assign w_live_slot[t] = (wr_en_i[t] && is_onehot(w_slot)) ? w_slot : {BUCKET_SIZE{1'b0}};
        assign w_new[t].adr         = wr_hash_adr_i[t*MAX_HASH_ADR_WIDTH +: MAX_HASH_ADR_WIDTH];
        assign w_new[t].data        = wr_data_i[t*DATA_WIDTH +: DATA_WIDTH];
        assign w_new[t].key         = wr_key_i[t*KEY_WIDTH +: KEY_WIDTH];
        assign w_new[t].updated_mem = w_live_slot[t];
        assign w_new[t].valid       = wr_valid_i[t] ? w_live_slot[t] : {BUCKET_SIZE{1'b0}};
    end

    for (genvar k = 0; k < FORWARDED_CLOCK_CYCLES; k++) begin : g_stage
        for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_tbl
            if (k == 0) begin : g_head
                // Stage 0 takes the new write, which survives a same-cycle flush.
                forward_history_stage u_stage (
                    .clk              (clk),
                    .reset            (reset),
                    .i_clk_en         (clk_en),
                    .i_flush          (flush_i),
                    .i_clear_incoming (1'b0),
                    .i_rec            (w_new[t]),
                    .i_drop_mask      ({BUCKET_SIZE{1'b0}}),
                    .o_rec            (w_rec[k][t])
                );
            end else begin : g_tail
                logic [BUCKET_SIZE-1:0] w_drop;
`ifdef FWD_HISTORY_COLLAPSE_EN
                // An older record at the freshly written address loses that slot.
                assign w_drop = (w_rec[k-1][t].adr == w_new[t].adr) ?
                                w_live_slot[t] : {BUCKET_SIZE{1'b0}};
`else
                assign w_drop = {BUCKET_SIZE{1'b0}};
`endif
                forward_history_stage u_stage (
                    .clk              (clk),
                    .reset            (reset),
                    .i_clk_en         (clk_en),
                    .i_flush          (flush_i),
                    .i_clear_incoming (flush_i),
                    .i_rec            (w_rec[k-1][t]),
                    .i_drop_mask      (w_drop),
                    .o_rec            (w_rec[k][t])
                );
            end

            assign fwd_hash_adr_o[(k*NUMBER_OF_TABLES+t)*MAX_HASH_ADR_WIDTH +: MAX_HASH_ADR_WIDTH] = w_rec[k][t].adr;
            assign fwd_data_o[(k*NUMBER_OF_TABLES+t)*DATA_WIDTH +: DATA_WIDTH]          = w_rec[k][t].data;
            assign fwd_key_o[(k*NUMBER_OF_TABLES+t)*KEY_WIDTH +: KEY_WIDTH]             = w_rec[k][t].key;
            assign fwd_updated_mem_o[(k*NUMBER_OF_TABLES+t)*BUCKET_SIZE +: BUCKET_SIZE] = w_rec[k][t].updated_mem;
            assign fwd_valid_o[(k*NUMBER_OF_TABLES+t)*BUCKET_SIZE +: BUCKET_SIZE]       = w_rec[k][t].valid;
        end
    end

    // Sticky malformed-slot flag; it updates whether or not the history advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_err <= 1'b0;
        end else begin
            r_slot_err <= r_slot_err | (|w_bad);
        end
    end

    assign slot_err_o = r_slot_err;

endmodule

// File: tb/tb_forward_history_buffer.sv
// Self-checking bench for forward_history_buffer: directed cases plus
// randomized traffic compared against a queue-based history model.
module tb_forward_history_buffer;

    localparam int KW = 4;
    localparam int DW = 8;
    localparam int NT = 3;
    localparam int BS = 2;
    localparam int F  = 2;
    localparam int AW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clk_en;
    logic                 flush_i;
    logic [NT-1:0]        wr_en_i;
    logic [AW*NT-1:0]     wr_hash_adr_i;
    logic [BS*NT-1:0]     wr_slot_i;
    logic [DW*NT-1:0]     wr_data_i;
    logic [KW*NT-1:0]     wr_key_i;
    logic [NT-1:0]        wr_valid_i;
    logic [AW*NT*F-1:0]   fwd_hash_adr_o;
    logic [DW*NT*F-1:0]   fwd_data_o;
    logic [KW*NT*F-1:0]   fwd_key_o;
    logic [BS*NT*F-1:0]   fwd_updated_mem_o;
    logic [BS*NT*F-1:0]   fwd_valid_o;
    logic                 slot_err_o;

    forward_history_buffer #(
        .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(NT),
        .BUCKET_SIZE(BS), .FORWARDED_CLOCK_CYCLES(F), .MAX_HASH_ADR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_hash_adr_i(wr_hash_adr_i), .wr_slot_i(wr_slot_i),
        .wr_data_i(wr_data_i), .wr_key_i(wr_key_i), .wr_valid_i(wr_valid_i),
        .fwd_hash_adr_o(fwd_hash_adr_o), .fwd_data_o(fwd_data_o), .fwd_key_o(fwd_key_o),
        .fwd_updated_mem_o(fwd_updated_mem_o), .fwd_valid_o(fwd_valid_o),
        .slot_err_o(slot_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: per table, a queue of records, youngest at the front.
    typedef struct {
        int adr; int data; int key; int upd; int val;
    } rec_t;

    rec_t hist [NT][$];
    bit   m_err;

    task automatic model_edge();
        rec_t r;
        rec_t z;
        int   slot;
        z = '{adr: 0, data: 0, key: 0, upd: 0, val: 0};
        if (reset) begin
            for (int t = 0; t < NT; t++) begin
                hist[t].delete();
                for (int k = 0; k < F; k++) hist[t].push_back(z);
            end
            m_err = 1'b0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                slot = int'(wr_slot_i[t*BS +: BS]);
                if (wr_en_i[t] && $countones(slot) != 1) m_err = 1'b1;
                if (flush_i) begin
                    for (int i = 0; i < hist[t].size(); i++) begin
                        r = hist[t][i];
                        r.upd = 0;
                        r.val = 0;
                        hist[t][i] = r;
                    end
                end
                if (clk_en) begin
                    rec_t n;
                    n.adr  = int'(wr_hash_adr_i[t*AW +: AW]);
                    n.data = int'(wr_data_i[t*DW +: DW]);
                    n.key  = int'(wr_key_i[t*KW +: KW]);
                    n.upd  = (wr_en_i[t] && $countones(slot) == 1) ? slot : 0;
                    n.val  = wr_valid_i[t] ? n.upd : 0;
`ifdef FWD_HISTORY_COLLAPSE_EN
                    for (int i = 0; i < hist[t].size(); i++) begin
                        r = hist[t][i];
                        if (r.adr == n.adr) begin
                            r.upd = r.upd & ~n.upd;
                            r.val = r.val & ~n.upd;
                        end
                        hist[t][i] = r;
                    end
`endif
                    hist[t].push_front(n);
                    void'(hist[t].pop_back());
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] e_adr, e_data, e_key, e_upd, e_val;
        int idx;
        e_adr = 64'd0; e_data = 64'd0; e_key = 64'd0; e_upd = 64'd0; e_val = 64'd0;
        for (int k = 0; k < F; k++) begin
            for (int t = 0; t < NT; t++) begin
                idx = k*NT + t;
                e_adr  = e_adr  | (64'(hist[t][k].adr)  << (idx*AW));
                e_data = e_data | (64'(hist[t][k].data) << (idx*DW));
                e_key  = e_key  | (64'(hist[t][k].key)  << (idx*KW));
                e_upd  = e_upd  | (64'(hist[t][k].upd)  << (idx*BS));
                e_val  = e_val  | (64'(hist[t][k].val)  << (idx*BS));
            end
        end
        check_eq("adr",      64'(fwd_hash_adr_o),    e_adr);
        check_eq("data",     64'(fwd_data_o),        e_data);
        check_eq("key",      64'(fwd_key_o),         e_key);
        check_eq("upd_mem",  64'(fwd_updated_mem_o), e_upd);
        check_eq("valid",    64'(fwd_valid_o),       e_val);
        check_eq("slot_err", 64'(slot_err_o),        64'(m_err));
    endtask

    // One clock edge: update the model from current inputs, then sample the DUT.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_writes();
        wr_en_i = '0; wr_hash_adr_i = '0; wr_slot_i = '0;
        wr_data_i = '0; wr_key_i = '0; wr_valid_i = '0;
    endtask

    task automatic set_write(input int t, input logic [AW-1:0] adr, input logic [BS-1:0] slot,
                             input logic [DW-1:0] data, input logic [KW-1:0] key, input logic v);
        wr_en_i[t]               = 1'b1;
        wr_hash_adr_i[t*AW +: AW] = adr;
        wr_slot_i[t*BS +: BS]     = slot;
        wr_data_i[t*DW +: DW]     = data;
        wr_key_i[t*KW +: KW]      = key;
        wr_valid_i[t]            = v;
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; flush_i = 1'b0;
        clear_writes();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) step();
        check_eq("idle_upd", 64'(fwd_updated_mem_o), 64'd0);
        check_eq("idle_err", 64'(slot_err_o), 64'd0);

        // Single write travels through the history and leaves
        set_write(0, 3'b001, 2'b01, 8'h01, 4'h1, 1'b1);
        step();
        check_eq("w1_s0_upd", 64'(fwd_updated_mem_o[1:0]), 64'd1);
        check_eq("w1_s0_val", 64'(fwd_valid_o[1:0]), 64'd1);
        check_eq("w1_s0_adr", 64'(fwd_hash_adr_o[2:0]), 64'd1);
        clear_writes();
        step();
        check_eq("w1_s1_upd", 64'(fwd_updated_mem_o[7:6]), 64'd1);
        check_eq("w1_s0_empty", 64'(fwd_updated_mem_o[1:0]), 64'd0);
        step();
        check_eq("w1_gone", 64'(fwd_updated_mem_o), 64'd0);

        // Stall holds the record; writes while stalled are ignored
        set_write(0, 3'b001, 2'b01, 8'h01, 4'h1, 1'b1);
        step();
        clk_en = 1'b0;
        clear_writes();
        set_write(0, 3'b010, 2'b10, 8'h22, 4'h2, 1'b1);
        step();
        step();
        check_eq("stall_upd", 64'(fwd_updated_mem_o[1:0]), 64'd1);
        check_eq("stall_adr", 64'(fwd_hash_adr_o[2:0]), 64'd1);
        clk_en = 1'b1;
        clear_writes();
        step();

        // Malformed slot on table 2 is dropped and flags a sticky error
        set_write(2, 3'b011, 2'b11, 8'h33, 4'h3, 1'b1);
        step();
        check_eq("bad_s0_t2", 64'(fwd_updated_mem_o[5:4]), 64'd0);
        check_eq("bad_err", 64'(slot_err_o), 64'd1);
        clear_writes();
        step();
        step();
        check_eq("bad_err_sticky", 64'(slot_err_o), 64'd1);

        // Flush with simultaneous write: only the new write survives
        set_write(0, 3'b101, 2'b01, 8'h55, 4'h5, 1'b1);
        set_write(1, 3'b110, 2'b10, 8'h66, 4'h6, 1'b1);
        step();
        step();
        clear_writes();
        flush_i = 1'b1;
        set_write(1, 3'b100, 2'b10, 8'h44, 4'h4, 1'b0);
        step();
        check_eq("flush_upd", 64'(fwd_updated_mem_o), 64'h008);
        check_eq("flush_val", 64'(fwd_valid_o), 64'h000);
        flush_i = 1'b0;
        clear_writes();

        // Repeated write to the same table/address/slot
        set_write(0, 3'b001, 2'b01, 8'h01, 4'h1, 1'b1);
        step();
        step();
        check_eq("dup_s0", 64'(fwd_updated_mem_o[1:0]), 64'd1);
`ifdef FWD_HISTORY_COLLAPSE_EN
        check_eq("dup_s1", 64'(fwd_updated_mem_o[7:6]), 64'd0);
`else
        check_eq("dup_s1", 64'(fwd_updated_mem_o[7:6]), 64'd1);
`endif
        clear_writes();

        // Reset mid-history discards everything and clears the error flag
        reset = 1'b1;
        step();
        check_eq("rst_upd", 64'(fwd_updated_mem_o), 64'd0);
        check_eq("rst_err", 64'(slot_err_o), 64'd0);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 99) < 2);
            clk_en  = ($urandom_range(0, 99) < 75);
            flush_i = ($urandom_range(0, 99) < 8);
            for (int t = 0; t < NT; t++) begin
                wr_en_i[t]               = ($urandom_range(0, 99) < 60);
                wr_hash_adr_i[t*AW +: AW] = AW'($urandom_range(0, 3));
                wr_slot_i[t*BS +: BS]     = ($urandom_range(0, 99) < 10) ?
                                            BS'($urandom_range(0, 3)) :
                                            BS'($urandom_range(1, 2));
                wr_data_i[t*DW +: DW]     = DW'($urandom);
                wr_key_i[t*KW +: KW]      = KW'($urandom);
                wr_valid_i[t]            = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_history_buffer.md
Name: forward_history_buffer

Overview:
- Produces the forwarding records consumed by whole_forward_updater: captures every committed bucket-slot write, per table, and keeps it for FORWARDED_CLOCK_CYCLES cycles.
- Sits beside the table write ports.
- Record fields match the forward_*_i record fields of whole_forward_updater: hash address, data, key, updated-slot mask and valid mask.
- Stage 0 holds the youngest write.

Parameters:
- KEY_WIDTH, 4, key bits per slot.
- DATA_WIDTH, 8, data bits per slot.
- NUMBER_OF_TABLES, 3, number of cuckoo tables.
- BUCKET_SIZE, 2, slots per bucket.
- FORWARDED_CLOCK_CYCLES, 2, history depth in stages (>=1).
- MAX_HASH_ADR_WIDTH, 3, hash address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  global advance enable.
- flush_i  in  1  invalidate entire history.
- wr_en_i  in  [NUMBER_OF_TABLES-1:0]  table t writes this cycle.
- wr_hash_adr_i  in  MAX_HASH_ADR_WIDTH x NUMBER_OF_TABLES  bucket address written.
- wr_slot_i  in  BUCKET_SIZE x NUMBER_OF_TABLES  one-hot slot written.
- wr_data_i  in  DATA_WIDTH x NUMBER_OF_TABLES  data written.
- wr_key_i  in  KEY_WIDTH x NUMBER_OF_TABLES  key written.
- wr_valid_i  in  1 x NUMBER_OF_TABLES  valid bit written (0 = delete).
- fwd_hash_adr_o  out  MAX_HASH_ADR_WIDTH x NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES  record address.
- fwd_data_o  out  DATA_WIDTH x NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES  record data.
- fwd_key_o  out  KEY_WIDTH x NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES  record key.
- fwd_updated_mem_o  out  BUCKET_SIZE x NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES  slot mask of the record; all-zero = empty record.
- fwd_valid_o  out  BUCKET_SIZE x NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES  written valid bit, placed at the slot position.
- slot_err_o  out  1  sticky: malformed slot select seen.

Behaviour:
- Reset (synchronous, has priority over everything): all record fields 0, slot_err_o 0. Reset asserted mid-history discards every record on the next edge.
- Records are pure registers; outputs are driven directly from them.
- Capture occurs on a rising edge with clk_en=1:
  - stage k <= stage k-1 for k>=1;
  - stage 0 per table t <= {wr_hash_adr_i[t], wr_data_i[t], wr_key_i[t], updated_mem = wr_en_i[t] ? wr_slot_i[t] : 0, valid = wr_en_i[t] && wr_valid_i[t] ? wr_slot_i[t] : 0}.
- Latency: a write presented at edge n is visible on stage 0 after edge n, and on stage k after edge n+k.
- A record leaves the buffer after FORWARDED_CLOCK_CYCLES enabled edges.
- clk_en=0: all stages hold; writes presented that cycle are ignored. slot_err_o still updates.
- Address, data and key fields of empty records keep the captured values; consumers must qualify with updated_mem.
- Slot check:
  - wr_en_i[t]=1 with wr_slot_i[t] not one-hot (zero or >1 bit): the write is dropped (updated_mem=0, valid=0) and slot_err_o is set.
  - slot_err_o stays set until reset.
- flush_i=1 (with reset=0):
  - every stage's updated_mem and valid is cleared on that edge, regardless of clk_en;
  - if clk_en=1 in the same cycle, the current write is still captured into stage 0 after the clear.
  - Net result: only the new write survives.
- Tables are independent: simultaneous writes to all tables are all captured.
- The same address/slot may appear in several stages. Consumers apply youngest-wins (lowest stage index).

Optional Feature:
- Macro: FWD_HISTORY_COLLAPSE_EN.
- Defined: on capture, any older stage record of the same table with equal hash address has the newly written slot bit cleared in both updated_mem and valid. At most one live record per (table, address, slot) exists. This is a per-stage address compare and mask.
- Undefined: no dedup; duplicates are allowed and youngest-wins applies downstream.

Decomposition:
- Shared package fwd_pkg holds the fwd_record_t struct typedef (adr, data, key, updated_mem, valid; sized from parameters via a parameterised struct or localparams) and an is_onehot function.
- One natural sub-module: forward_history_stage. It holds one table's record register, with shift/flush/collapse inputs. It is instantiated NUMBER_OF_TABLES x FORWARDED_CLOCK_CYCLES times.

Test Plan:
- Reset then idle: after 3 enabled edges, all fwd_updated_mem_o = 2'b00 and slot_err_o = 0.
- Table 0 write adr=3'b001, slot=2'b01, key=4'h1, data=8'h01, valid=1:
  - after edge 1: stage0 t0 {001, 01, valid 01};
  - after edge 2: the record is in stage1 and stage0 t0 mask = 00;
  - after edge 3: the record is gone.
- Same write with clk_en=0 for 2 cycles between edges: the record holds in stage0; the write presented while disabled never appears.
- Write on t2 with slot=2'b11: dropped; stage0 t2 mask 00; slot_err_o=1 and stays 1 until reset.
- History holding two records, then flush_i=1 with a simultaneous t1 write adr=3'b100, slot=2'b10, valid=0: only stage0 t1 is live, with mask 10 and valid 00.
- FWD_HISTORY_COLLAPSE_EN: t0 writes adr=001, slot=01 on two consecutive edges:
  - defined: stage1 mask 00, stage0 mask 01;
  - undefined: both stage masks 01.
